// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: decodes the EX/MEM access, runs a req/gnt/rvalid
// handshake on a word-addressed data port, stalls the pipeline until the access
// completes and returns lane-selected, sign/zero-extended load data.
module mem_stage_lsu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic [2:0]       Funct3M,
    input  logic [WIDTH-1:0] AluResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    output logic             StallM,
    output logic [WIDTH-1:0] ReadDataM,
    output logic             MisalignM,
    output logic             IllegalM,
    output logic             BusErrM,
    output logic             DMemReq,
    output logic             DMemWe,
    output logic [WIDTH-1:0] DMemAddr,
    output logic [3:0]       DMemBe,
    output logic [WIDTH-1:0] DMemWData,
    input  logic             DMemGnt,
    input  logic             DMemRValid,
    input  logic [WIDTH-1:0] DMemRData
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;

    // Access attributes captured when the request is launched.
    logic [WIDTH-1:0]  addr_q;
    logic [2:0]        f3_q;
    logic [3:0]        be_q;
    logic [WIDTH-1:0]  wdata_q;
    logic              we_q;

    logic              op, is_load, legal, misaligned;
    logic [3:0]        be_c;
    logic [WIDTH-1:0]  wdata_c;
    logic [WIDTH-1:0]  shifted;
    logic [WIDTH-1:0]  load_ext;
    logic              timeout;
    logic              launch, stall, req, misalign_f, illegal_f;

    // Decode the incoming M-stage access: legality, alignment, byte mask, store lanes.
    always_comb begin
        op      = MemReadM | MemWriteM;
        is_load = MemReadM;  // read wins when both are set
        legal   = 1'b0;
        if (is_load) begin
            case (Funct3M)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end else begin
            legal = (Funct3M[2] == 1'b0) && (Funct3M[1:0] != 2'b11);
        end
        case (Funct3M[1:0])
            2'b00: begin
                misaligned = 1'b0;
                be_c       = 4'b0001 << AluResultM[1:0];
                wdata_c    = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                misaligned = AluResultM[0];
                be_c       = 4'b0011 << {AluResultM[1], 1'b0};
                wdata_c    = {2{WriteDataM[15:0]}};
            end
            default: begin
                misaligned = |AluResultM[1:0];
                be_c       = 4'b1111;
                wdata_c    = WriteDataM;
            end
        endcase
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        shifted = DMemRData >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Handshake FSM next-state, timeout tracking and per-state outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        launch     = 1'b0;
        stall      = 1'b0;
        req        = 1'b0;
        misalign_f = 1'b0;
        illegal_f  = 1'b0;
        timeout    = (cnt_q == CntW'(TIMEOUT_CYC - 1));
        case (state_q)
            StIdle: begin
                if (op) begin
                    if (!legal) begin
                        illegal_f = 1'b1;
                    end else if (misaligned) begin
                        misalign_f = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        launch  = 1'b1;
                        cnt_d   = '0;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                req   = 1'b1;
                stall = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (DMemGnt) begin
                    state_d = we_q ? StDone : StData;
                end else if (timeout) begin
                    state_d   = StDone;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            StData: begin
                stall = 1'b1;
                cnt_d = cnt_q + CntW'(1);
                if (DMemRValid) begin
                    rdata_d = load_ext;
                    state_d = StDone;
                end else if (timeout) begin
                    state_d   = StDone;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter, result and captured-access registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            addr_q    <= '0;
            f3_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
            if (launch) begin
                addr_q  <= AluResultM;
                f3_q    <= Funct3M;
                be_q    <= be_c;
                wdata_q <= wdata_c;
                we_q    <= ~is_load;
            end
        end
    end

    // Control outputs are forced low while reset is held, whatever the state.
    always_comb begin
        StallM    = stall & ~RST;
        DMemReq   = req & ~RST;
        DMemWe    = req & we_q & ~RST;
        MisalignM = misalign_f & ~RST;
        IllegalM  = illegal_f & ~RST;
        BusErrM   = bus_err_q & ~RST;
        ReadDataM = rdata_q;
        DMemAddr  = {addr_q[WIDTH-1:2], 2'b00};
        DMemBe    = be_q;
        DMemWData = wdata_q;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses compared against a byte-level behavioural model of RV32I loads/stores.
module tb_mem_stage_lsu;

    localparam int TIMEOUT_CYC = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] AluResultM, WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MisalignM, IllegalM, BusErrM;
    logic        DMemReq, DMemWe;
    logic [31:0] DMemAddr;
    logic [3:0]  DMemBe;
    logic [31:0] DMemWData;
    logic        DMemGnt, DMemRValid;
    logic [31:0] DMemRData;

    int vectors = 0;
    int miscompares = 0;

    mem_stage_lsu #(.WIDTH(32), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLK(CLK), .RST(RST), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .Funct3M(Funct3M), .AluResultM(AluResultM), .WriteDataM(WriteDataM),
        .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM),
        .IllegalM(IllegalM), .BusErrM(BusErrM), .DMemReq(DMemReq), .DMemWe(DMemWe),
        .DMemAddr(DMemAddr), .DMemBe(DMemBe), .DMemWData(DMemWData),
        .DMemGnt(DMemGnt), .DMemRValid(DMemRValid), .DMemRData(DMemRData)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- reference model: RV32I access rules as plain arithmetic ----
    function automatic bit m_legal(input bit ld, input logic [2:0] f3);
        if (ld) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return f3 inside {3'd0, 3'd1, 3'd2};
    endfunction

    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % m_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int mask;
        mask = ((1 << m_size(f3)) - 1) << int'(a[1:0]);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        longint sh, mask, v;
        int bits;
        bits = 8 * m_size(f3);
        sh   = longint'({32'h0, rd}) >> (8 * int'(a[1:0]));
        mask = (longint'(1) << bits) - 1;
        v    = sh & mask;
        if (!f3[2] && bits < 32 && v[bits-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One M-stage access from its IDLE cycle through DONE, with gw grant-wait and
    // rw rvalid-wait cycles. Junk rvalid is driven in REQ wait cycles (must be ignored).
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdata,
                          input int gw, input int rw);
        bit ld, lg, ms;
        ld = rd;
        lg = m_legal(ld, f3);
        ms = lg && m_misal(f3, addr);
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; AluResultM = addr; WriteDataM = wd;
        @(negedge CLK);
        chk({tag, ".illegal"}, IllegalM, !lg);
        chk({tag, ".misalign"}, MisalignM, ms);
        chk({tag, ".idle_req"}, DMemReq, 1'b0);
        chk({tag, ".idle_stall"}, StallM, lg && !ms);
        @(posedge CLK); #1;
        if (!lg || ms) begin
            MemReadM = 1'b0; MemWriteM = 1'b0;
            @(negedge CLK);
            chk({tag, ".stay_idle"}, {StallM, DMemReq, MisalignM, IllegalM}, 4'b0000);
            @(posedge CLK); #1;
            return;
        end
        for (int i = 0; i <= gw; i++) begin
            DMemGnt    = (i == gw);
            DMemRValid = (i != gw);
            DMemRData  = $urandom;
            @(negedge CLK);
            chk({tag, ".req"}, DMemReq, 1'b1);
            chk({tag, ".req_stall"}, StallM, 1'b1);
            chk({tag, ".addr"}, DMemAddr, {addr[31:2], 2'b00});
            chk({tag, ".be"}, DMemBe, m_be(f3, addr));
            chk({tag, ".we"}, DMemWe, !ld);
            if (!ld) chk({tag, ".wdata"}, DMemWData, m_wdata(f3, wd));
            @(posedge CLK); #1;
        end
        DMemGnt = 1'b0;
        DMemRValid = 1'b0;
        if (ld) begin
            for (int i = 0; i <= rw; i++) begin
                DMemRValid = (i == rw);
                DMemRData  = (i == rw) ? rdata : $urandom;
                @(negedge CLK);
                chk({tag, ".data_req"}, DMemReq, 1'b0);
                chk({tag, ".data_stall"}, StallM, 1'b1);
                @(posedge CLK); #1;
            end
            DMemRValid = 1'b0;
        end
        @(negedge CLK);
        chk({tag, ".done_stall"}, StallM, 1'b0);
        chk({tag, ".done_buserr"}, BusErrM, 1'b0);
        chk({tag, ".done_req"}, DMemReq, 1'b0);
        if (ld) chk({tag, ".rdata"}, ReadDataM, m_load(f3, addr, rdata));
        @(posedge CLK); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    initial begin
        int n;
        logic rd, wr;
        RST = 1'b1;
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010;
        AluResultM = 32'h0000_0040; WriteDataM = 32'h0;
        DMemGnt = 1'b0; DMemRValid = 1'b0; DMemRData = 32'h0;

        // Reset: a legal load is presented but nothing may happen while RST is high.
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst.hold", {StallM, DMemReq, DMemWe, MisalignM, IllegalM, BusErrM}, 6'b0);
        chk("rst.rdata", ReadDataM, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b0; MemReadM = 1'b0;
        @(negedge CLK);
        chk("rst.idle", {StallM, DMemReq, DMemWe, MisalignM, IllegalM, BusErrM}, 6'b0);
        @(posedge CLK); #1;

        // Directed scenarios.
        access("sw",  1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        access("lb",  1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_0000, 2, 0);
        access("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'hBEEF_1234, 0, 1);
        access("sh",  1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 0);
        access("lwmis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
        access("ill", 1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
        access("both", 1'b1, 1'b1, 3'b100, 32'h0000_0311, 32'h0, 32'hC3A5_9F81, 0, 0);

        // Timeout: grant immediately, never return data.
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; AluResultM = 32'h0000_0400;
        @(negedge CLK);
        chk("to.idle_stall", StallM, 1'b1);
        @(posedge CLK); #1;
        DMemGnt = 1'b1;
        @(negedge CLK);
        chk("to.req", DMemReq, 1'b1);
        @(posedge CLK); #1;
        DMemGnt = 1'b0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!StallM) break;
            n++;
            @(posedge CLK); #1;
        end
        chk("to.cycles", n, TIMEOUT_CYC);
        chk("to.buserr", BusErrM, 1'b1);
        chk("to.rdata", ReadDataM, 32'h0);
        chk("to.req_dropped", DMemReq, 1'b0);
        @(posedge CLK); #1;
        MemReadM = 1'b0;
        @(negedge CLK);
        chk("to.idle", {BusErrM, StallM, DMemReq}, 3'b000);
        @(posedge CLK); #1;

        // Load data so ReadDataM is non-zero before the reset-in-DATA case.
        access("lw", 1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'h1234_5678, 0, 0);

        // Reset asserted in DATA; rvalid arrives the cycle after and must be ignored.
        MemReadM = 1'b1; Funct3M = 3'b010; AluResultM = 32'h0000_0300;
        @(posedge CLK); #1;
        DMemGnt = 1'b1;
        @(posedge CLK); #1;
        DMemGnt = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        chk("mid.rst_stall", {StallM, DMemReq}, 2'b00);
        @(posedge CLK); #1;
        RST = 1'b0; MemReadM = 1'b0;
        DMemRValid = 1'b1; DMemRData = 32'hFACE_CAFE;
        @(negedge CLK);
        chk("mid.idle", {StallM, DMemReq}, 2'b00);
        chk("mid.rdata", ReadDataM, 32'h0);
        @(posedge CLK); #1;
        DMemRValid = 1'b0;
        @(negedge CLK);
        chk("mid.rdata_hold", ReadDataM, 32'h0);
        chk("mid.stall_hold", StallM, 1'b0);
        @(posedge CLK); #1;

        // Randomized accesses.
        for (int k = 0; k < 40; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            access("rnd", rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the Memory stage of the 5-stage RV32I pipeline. It consumes the EX/MEM pipeline-register outputs (address, store data, control) and drives a word-addressed data-memory port with a req/gnt/rvalid handshake. It holds the pipeline with StallM until the access completes, then presents aligned, sign- or zero-extended load data to the MEM/WB path. Misaligned and illegal accesses are flagged without touching memory.

## Interface
Parameters:
- WIDTH, 32, data/address width (only 32 supported)
- TIMEOUT_CYC, 16, max cycles spent in REQ+DATA before bus error

Ports:
- CLK  in  1  clock, all state updates on posedge
- RST  in  1  synchronous, active-high reset
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- Funct3M  in  3  access size/sign (RV32I load/store funct3)
- AluResultM  in  32  byte address
- WriteDataM  in  32  store data (RD2)
- StallM  out  1  hold IF/ID/EX and EX/MEM registers
- ReadDataM  out  32  extended load data, valid in DONE
- MisalignM  out  1  one-cycle flag, misaligned access
- IllegalM  out  1  one-cycle flag, reserved funct3
- BusErrM  out  1  flag in DONE on timeout
- DMemReq  out  1  request valid
- DMemWe  out  1  1=store, 0=load
- DMemAddr  out  32  {AluResultM[31:2],2'b00}
- DMemBe  out  4  byte enables
- DMemWData  out  32  lane-replicated store data
- DMemGnt  in  1  request accepted this cycle
- DMemRValid  in  1  load data valid
- DMemRData  in  32  load data word

## Operation
- op = MemReadM|MemWriteM. Both high together: treated as load.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Anything else: IllegalM.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0.
- DMemBe: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111. Loads drive the same mask.
- DMemWData: byte replicated x4, half replicated x2, word as-is.
- Load extract: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- FSM states IDLE, REQ, DATA, DONE:
  - IDLE: op & legal & aligned -> StallM=1, next REQ. op & (illegal|misaligned) -> flag high this cycle, StallM=0, stay IDLE. No op -> stay.
  - REQ: DMemReq=1, StallM=1. DMemGnt: store -> DONE, load -> DATA. Otherwise hold req and all DMem* stable.
  - DATA: StallM=1, DMemReq=0. DMemRValid -> capture extended data into ReadDataM register, next DONE.
  - DONE: StallM=0, ReadDataM stable; pipeline advances at this edge; next IDLE.
- Timeout counter: cleared on IDLE->REQ, increments each cycle in REQ/DATA. When it reaches TIMEOUT_CYC-1 without completion -> DONE with BusErrM=1, ReadDataM=0, DMemReq dropped.
- DMemRValid outside DATA is ignored.

## Timing
- Reset: state IDLE, counter 0, ReadDataM 0; StallM, DMemReq, DMemWe, MisalignM, IllegalM, BusErrM all 0 in the cycle after the reset edge and while RST is high.
- Reset mid-access: return to IDLE at that edge; DMemReq low next cycle; late DMemRValid ignored.
- Store with immediate grant: IDLE, REQ, DONE = 3 cycles, StallM high for 2.
- Load with gnt in REQ's first cycle and rvalid in DATA's first cycle: 4 cycles, StallM high for 3; ReadDataM valid in DONE.
- Each extra gnt/rvalid wait cycle adds one stall cycle.
- rvalid may arrive no earlier than the cycle after gnt.
- Flags are combinational from M inputs in IDLE (MisalignM, IllegalM) or registered (BusErrM, DONE only); never overlap StallM=1.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, gnt immediate -> DMemAddr 0x100, Be 1111, We 1, StallM 2 cycles, then DONE.
- LB addr 0x203, rdata 0x80FF_0000, gnt after 2 wait cycles -> Be 1000, ReadDataM 0xFFFFFF80 in DONE, StallM 5 cycles.
- LHU addr 0x202, rdata 0xBEEF_1234 -> ReadDataM 0x0000BEEF; SH addr 0x202 data 0x0000ABCD -> Be 1100, WData 0xABCDABCD.
- LW addr 0x101 -> MisalignM 1 for one cycle, DMemReq never asserted, StallM 0; funct3 011 load -> IllegalM 1.
- Load, gnt given, no rvalid for TIMEOUT_CYC cycles -> BusErrM 1 in DONE, ReadDataM 0, next state IDLE.
- RST asserted in DATA, rvalid arrives next cycle -> state IDLE, StallM 0, ReadDataM unchanged at 0.
